// File: rtl/adxl_axis_reader.sv
// rtl/adxl_axis_reader.sv - ADXL362 SPI bring-up and periodic X-axis burst reader; ADXL_YZ_EN adds Y/Z axes
module adxl_axis_reader #(
    parameter int CLK_DIV        = 50,
    parameter int STARTUP_CYCLES = 600000,
    parameter int SAMPLE_PERIOD  = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] x_axis_out,
`ifdef ADXL_YZ_EN
    output logic [15:0] y_axis_out,
    output logic [15:0] z_axis_out,
`endif
    output logic        x_valid,
    output logic        busy
);

`ifdef ADXL_YZ_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 2;
`endif
    localparam int RX_W = 8 * NBYTES;
    localparam int TX_W = 16 + RX_W;

    typedef enum logic [2:0] {ST_STARTUP, ST_CFG, ST_IDLE, ST_READ, ST_DONE} state_t;
    // PRE keeps CS high for 2*CLK_DIV cycles so the CS-high gap is guaranteed and latency is fixed
    typedef enum logic [1:0] {PH_PRE, PH_LOW, PH_HIGH, PH_HOLD} phase_t;

    state_t          state;
    phase_t          phase;
    logic [31:0]     timer;
    logic [31:0]     tick_cnt;
    logic [31:0]     ph_cnt;
    logic [6:0]      bit_cnt;
    logic [6:0]      n_bits;
    logic [TX_W-1:0] tx_sr;
    logic [RX_W-1:0] rx_sr;
    logic            tick;
    logic            pending;
    logic            started;
    logic            unused_hi_nibbles;

    // 12-bit two's complement sample: H[3:0] are the upper bits, H[3] is the sign
    function automatic logic [15:0] sext12(input logic [7:0] lo, input logic [3:0] hi);
        return {{4{hi[3]}}, hi, lo};
    endfunction

    assign tick = (tick_cnt == 32'(SAMPLE_PERIOD - 1));
    assign busy = started && ((state != ST_IDLE) || !spi_cs_n);

`ifdef ADXL_YZ_EN
    assign unused_hi_nibbles = ^{rx_sr[39:36], rx_sr[23:20], rx_sr[7:4]};
`else
    assign unused_hi_nibbles = ^rx_sr[7:4];
`endif

    // Free-running sample tick counter
    always_ff @(posedge clk_in) begin
        if (rst_in || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    // Sequencer: startup wait, config write, periodic burst read, sample assembly
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_STARTUP;
            phase      <= PH_PRE;
            timer      <= '0;
            ph_cnt     <= '0;
            bit_cnt    <= '0;
            n_bits     <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            pending    <= 1'b0;
            started    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            x_axis_out <= '0;
`ifdef ADXL_YZ_EN
            y_axis_out <= '0;
            z_axis_out <= '0;
`endif
            x_valid    <= 1'b0;
        end else begin
            started <= 1'b1;
            x_valid <= 1'b0;
            // IDLE consumes ticks directly; anywhere else a tick is remembered once
            if (tick && state != ST_IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                ST_STARTUP: begin
                    if (timer == 32'(STARTUP_CYCLES - 1)) begin
                        state   <= ST_CFG;
                        phase   <= PH_PRE;
                        ph_cnt  <= '0;
                        bit_cnt <= '0;
                        n_bits  <= 7'd24;
                        tx_sr   <= {24'h0A2D02, {(TX_W-24){1'b0}}};
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (tick || pending) begin
                        pending <= 1'b0;
                        state   <= ST_READ;
                        phase   <= PH_PRE;
                        ph_cnt  <= '0;
                        bit_cnt <= '0;
                        n_bits  <= 7'(TX_W);
                        tx_sr   <= {16'h0B0E, {RX_W{1'b0}}};
                    end
                end
                ST_CFG, ST_READ: begin
                    case (phase)
                        PH_PRE: begin
                            if (ph_cnt == 32'(2 * CLK_DIV - 1)) begin
                                ph_cnt   <= '0;
                                phase    <= PH_LOW;
                                spi_cs_n <= 1'b0;
                                spi_mosi <= tx_sr[TX_W-1];
                                tx_sr    <= tx_sr << 1;
                            end else begin
                                ph_cnt <= ph_cnt + 32'd1;
                            end
                        end
                        PH_LOW: begin
                            if (ph_cnt == 32'(CLK_DIV - 1)) begin
                                ph_cnt   <= '0;
                                phase    <= PH_HIGH;
                                spi_sclk <= 1'b1;
                                rx_sr    <= {rx_sr[RX_W-2:0], spi_miso};
                            end else begin
                                ph_cnt <= ph_cnt + 32'd1;
                            end
                        end
                        PH_HIGH: begin
                            if (ph_cnt == 32'(CLK_DIV - 1)) begin
                                ph_cnt   <= '0;
                                spi_sclk <= 1'b0;
                                bit_cnt  <= bit_cnt + 7'd1;
                                if (bit_cnt == n_bits - 7'd1) begin
                                    phase    <= PH_HOLD;
                                    spi_mosi <= 1'b0;
                                end else begin
                                    phase    <= PH_LOW;
                                    spi_mosi <= tx_sr[TX_W-1];
                                    tx_sr    <= tx_sr << 1;
                                end
                            end else begin
                                ph_cnt <= ph_cnt + 32'd1;
                            end
                        end
                        PH_HOLD: begin
                            if (ph_cnt == 32'(CLK_DIV - 1)) begin
                                ph_cnt   <= '0;
                                phase    <= PH_PRE;
                                spi_cs_n <= 1'b1;
                                state    <= (state == ST_READ) ? ST_DONE : ST_IDLE;
                            end else begin
                                ph_cnt <= ph_cnt + 32'd1;
                            end
                        end
                        default: phase <= PH_PRE;
                    endcase
                end
                ST_DONE: begin
`ifdef ADXL_YZ_EN
                    x_axis_out <= sext12(rx_sr[47:40], rx_sr[35:32]);
                    y_axis_out <= sext12(rx_sr[31:24], rx_sr[19:16]);
                    z_axis_out <= sext12(rx_sr[15:8], rx_sr[3:0]);
`else
                    x_axis_out <= sext12(rx_sr[15:8], rx_sr[3:0]);
`endif
                    x_valid <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

endmodule
